// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that lets NREQ clients share a
// single multi-cycle alu32. One request is accepted at a time. Its operands
// are held on the ALU while start is high. The ALU result, or a timeout
// error, is returned to the requester that won arbitration.
module alu_share_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_in1,
    input  logic [NREQ*32-1:0]  req_in2,
    input  logic [NREQ*3-1:0]   req_sel,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [31:0]         rsp_result,
    output logic                rsp_err,
    output logic                alu_start,
    output logic [31:0]         alu_in1,
    output logic [31:0]         alu_in2,
    output logic [2:0]          alu_sel,
    input  logic [31:0]         alu_result,
    input  logic                alu_done,
    output logic                busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last_grant, grant_id, winner;
    logic             any_req;
    logic [NREQ-1:0]  win_oh;
    logic [31:0]      sel_in1, sel_in2;
    logic [2:0]       sel_op;
    logic [31:0]      lat_in1, lat_in2, res_q;
    logic [2:0]       lat_sel;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic             tmo;

    assign tmo = (cnt == CW'(TIMEOUT - 1));

    // Round-robin pick: scan from last_grant+1 upward, wrapping. The scan runs
    // backwards so that the last assignment is the closest valid requester.
    always_comb begin
        winner  = '0;
        any_req = |req_valid;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NREQ;
            if (req_valid[idx]) winner = IDW'(idx);
        end
        win_oh = NREQ'(1) << winner;
    end

    // Operand mux for the winning requester's slice.
    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        sel_op  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_in1 = req_in1[i*32 +: 32];
                sel_in2 = req_in2[i*32 +: 32];
                sel_op  = req_sel[i*3 +: 3];
            end
        end
    end

    // State register. An asynchronous reset drops any in-flight op at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and output decode. Outputs are fully decoded from state, so
    // they fall to zero the moment reset forces IDLE.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_result = '0;
        rsp_err    = 1'b0;
        alu_start  = 1'b0;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_sel    = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by reset so that no accept is shown while reset is held.
                if (any_req && reset) req_ready = win_oh;
                if (any_req) state_nxt = BUSY;
            end
            BUSY: begin
                alu_start = 1'b1;
                alu_in1   = lat_in1;
                alu_in2   = lat_in2;
                alu_sel   = lat_sel;
                if (alu_done || tmo) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid  = NREQ'(1) << grant_id;
                rsp_result = res_q;
                rsp_err    = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch on accept, capture the result or a timeout, and rotate
    // priority once the response has gone out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_in1    <= '0;
            lat_in2    <= '0;
            lat_sel    <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
            cnt        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_in1  <= sel_in1;
                        lat_in2  <= sel_in2;
                        lat_sel  <= sel_op;
                        grant_id <= winner;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (alu_done) begin
                        // done has priority over a timeout on the same edge
                        res_q <= alu_result;
                        err_q <= 1'b0;
                    end else if (tmo) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. It runs a behavioural alu32 with a
// programmable done delay, a table of directed transactions, hand-written
// contention, reset and idle sequences, and randomized traffic. The
// randomized traffic is checked against a transaction-level round-robin model.
module tb_alu_share_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_in1, req_in2;
    logic [NREQ*3-1:0]   req_sel;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_result;
    logic                rsp_err;
    logic                alu_start;
    logic [31:0]         alu_in1, alu_in2;
    logic [2:0]          alu_sel;
    logic [31:0]         alu_result;
    logic                alu_done;
    logic                busy;

    int total = 0;
    int bad   = 0;

    int   alu_dly = 0;         // done on the Nth BUSY edge; 0 = never
    logic alu_force = 1'b0;    // force done high regardless of start
    int   acnt = 0;

    alu_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_done(alu_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a * b;
            default: return (b == 0) ? 32'd0 : a % b;
        endcase
    endfunction

    // Behavioural alu32: counts start-high cycles and raises done for one cycle.
    always @(negedge clk) begin
        if (alu_start) acnt = acnt + 1;
        else           acnt = 0;
        alu_done   = alu_force || (alu_start && alu_dly != 0 && acnt == alu_dly);
        alu_result = alu_ref(alu_in1, alu_in2, alu_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] s);
        req_in1[id*32 +: 32] = a;
        req_in2[id*32 +: 32] = b;
        req_sel[id*3 +: 3]   = s;
        req_valid[id]        = 1'b1;
    endtask

    // One full transaction, starting in IDLE with requester id expected to win.
    task automatic do_txn(input int id, input int dly, input logic [31:0] exp_res,
                          input logic exp_err, input logic [31:0] exp_in1, input bit keep);
        int k;
        int n;
        #1;
        chk("grant", 32'(req_ready), 32'(1) << id);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in1", alu_in1, 32'd0);
        alu_dly = dly;
        tick();
        if (!keep) req_valid[id] = 1'b0;
        chk("start", 32'(alu_start), 32'd1);
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("in1", alu_in1, exp_in1);
        k = (dly == 0 || dly > TIMEOUT) ? TIMEOUT : dly;
        n = 0;
        while (rsp_valid == '0 && n < TIMEOUT + 4) begin
            tick();
            n++;
            if (rsp_valid == '0) chk("hold_in1", alu_in1, exp_in1);
        end
        chk("latency", 32'(n), 32'(k));
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << id);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("resp_start", 32'(alu_start), 32'd0);
        tick();
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("back_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  s;
        int          dly;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    int lg;
    logic [NREQ-1:0] pend;
    logic [31:0] ra[NREQ], rb[NREQ];
    logic [2:0]  rs[NREQ];

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_sel   = '0;

        tbl[0] = '{0, 32'd20,         32'd3,      3'b111, 5,  32'd2,     1'b0}; // mod
        tbl[1] = '{0, 32'd7,          32'd5,      3'b000, 1,  32'd12,    1'b0}; // add, fastest ALU
        tbl[2] = '{1, 32'd100,        32'd58,     3'b001, 2,  32'd42,    1'b0};
        tbl[3] = '{2, 32'h0000F0F0,   32'h0FF0,   3'b010, 3,  32'h00F0,  1'b0};
        tbl[4] = '{0, 32'd5,          32'd6,      3'b110, 0,  32'd0,     1'b1}; // timeout
        tbl[5] = '{1, 32'd1,          32'd4,      3'b101, 16, 32'd16,    1'b0}; // done on timeout edge
        tbl[6] = '{2, 32'hFFFFFFFF,   32'd1,      3'b000, 15, 32'd0,     1'b0};
        tbl[7] = '{0, 32'h000000AA,   32'h55,     3'b100, 4,  32'h000000FF, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        req_valid = 3'b111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset = 1'b1;
        tick();

        // directed table
        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].s);
            do_txn(tbl[i].id, tbl[i].dly, tbl[i].res, tbl[i].err, tbl[i].a, 1'b0);
        end

        // contention between req0 and req1 after a fresh reset: strict alternation
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        set_req(0, 32'd10, 32'd1, 3'b000);
        set_req(1, 32'd20, 32'd2, 3'b000);
        for (int t = 0; t < 8; t++) begin
            int w;
            logic [31:0] a;
            w = t % 2;
            a = req_in1[w*32 +: 32];
            do_txn(w, 2, alu_ref(a, req_in2[w*32 +: 32], req_sel[w*3 +: 3]), 1'b0, a, 1'b1);
            set_req(w, a + 32'd1, 32'd3, 3'b001);
        end
        req_valid = '0;

        // reset mid-BUSY: req0 then req1; priority would favour req1 next, reset restores req0
        set_req(0, 32'd9, 32'd4, 3'b000);
        do_txn(0, 1, 32'd13, 1'b0, 32'd9, 1'b0);
        set_req(1, 32'd33, 32'd3, 3'b000);
        alu_dly = 0;
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        chk("midbusy_start", 32'(alu_start), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_start_now", 32'(alu_start), 32'd0);
        chk("rst_busy_now", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        #2 reset = 1'b1;
        tick();
        set_req(0, 32'd2, 32'd2, 3'b000);
        set_req(1, 32'd3, 32'd3, 3'b000);
        do_txn(0, 3, 32'd4, 1'b0, 32'd2, 1'b0);
        do_txn(1, 3, 32'd6, 1'b0, 32'd3, 1'b0);

        // alu_done held high in IDLE with no requests
        alu_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_done_busy", 32'(busy), 32'd0);
            chk("idle_done_rsp", 32'(rsp_valid), 32'd0);
        end
        alu_force = 1'b0;
        tick();

        // randomized traffic vs transaction-level round-robin model
        lg   = 1;   // last grant from the sequence above
        pend = '0;
        for (int t = 0; t < 40; t++) begin
            int w;
            int dly;
            logic [31:0] er;
            logic ee;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    ra[i] = $urandom;
                    rb[i] = $urandom_range(0, 40);
                    rs[i] = 3'($urandom_range(0, 7));
                    set_req(i, ra[i], rb[i], rs[i]);
                end
            end
            if (pend == '0) begin
                w = $urandom_range(0, NREQ - 1);
                pend[w] = 1'b1;
                ra[w] = $urandom;
                rb[w] = $urandom_range(1, 40);
                rs[w] = 3'($urandom_range(0, 7));
                set_req(w, ra[w], rb[w], rs[w]);
            end
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (lg + k) % NREQ;
                if (w < 0 && pend[j]) w = j;
            end
            dly = $urandom_range(0, TIMEOUT + 2);
            if (dly == 0 || dly > TIMEOUT) begin
                er = 32'd0;
                ee = 1'b1;
            end else begin
                er = alu_ref(ra[w], rb[w], rs[w]);
                ee = 1'b0;
            end
            do_txn(w, dly, er, ee, ra[w], 1'b0);
            pend[w] = 1'b0;
            lg = w;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
